video_pixel_shifter: RTL and testbench



---
 rtl/video_pixel_shifter_pkg.sv | 32 +++
 rtl/video_mode_sync.sv | 45 ++++
 rtl/video_pixel_shifter.sv | 71 +++++++
 tb/tb_video_pixel_shifter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/video_pixel_shifter_pkg.sv
// Shared gate-array definitions: screen modes, CIDX bit order and the per-mode
// pixel-shift mask applied to the incremented phase counter.
package video_pixel_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_t;

    // Shift-register bit feeding each CIDX bit, CIDX[0] in the low field: {1,5,3,7}.
    localparam logic [11:0] CIDX_ORDER = {3'd1, 3'd5, 3'd3, 3'd7};

    // Two-bit mask per mode, indexed by mode; a shift happens when (phase' & mask) == 0.
    // Mode 3 reuses mode-0 timing.
    localparam logic [7:0] SHIFT_MASK = {2'b11, 2'b00, 2'b01, 2'b11};

    function automatic logic [3:0] cidx_of(input logic [7:0] sr);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c[i] = sr[CIDX_ORDER[i*3 +: 3]];
        end
        return c;
    endfunction

    function automatic logic [1:0] shift_mask(input mode_t m);
        return SHIFT_MASK[{m, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/video_mode_sync.sv
// Latches MODE_REG on an HSYNC rise and commits it at the next byte load.
// One-clock registered decode; a rise coinciding with a load commits immediately.
module video_mode_sync
    import video_pixel_shifter_pkg::*;
(
    input  logic       clk_n,
    input  logic       reset_n,
    input  logic       hsync,
    input  logic [1:0] mode_reg,
    input  logic       byte_load,
    output mode_t      mode,
    output logic       mode_is_0,
    output logic       mode_is_2
);

    logic  hsync_d;
    mode_t pending_mode;
    mode_t pending_mode_next;

    always_comb begin
        pending_mode_next = pending_mode;
        if (hsync && !hsync_d) begin
            pending_mode_next = mode_t'(mode_reg);
        end
    end

    always_ff @(posedge clk_n) begin
        if (!reset_n) begin
            hsync_d      <= 1'b0;
            pending_mode <= MODE_0;
            mode         <= MODE_0;
            mode_is_0    <= 1'b1;
            mode_is_2    <= 1'b0;
        end else begin
            hsync_d      <= hsync;
            pending_mode <= pending_mode_next;
            if (byte_load) begin
                mode      <= pending_mode_next;
                mode_is_0 <= (pending_mode_next == MODE_0);
                mode_is_2 <= (pending_mode_next == MODE_2);
            end
        end
    end

endmodule

// File: rtl/video_pixel_shifter.sv
// Serialises one video byte per slot into colour indices at the committed mode rate.
// First pixel valid the cycle after BYTE_LOAD; free-running, no backpressure.
module video_pixel_shifter
    import video_pixel_shifter_pkg::*;
(
    input  logic       CLK_n,
    input  logic       RESET_n,
    input  logic [7:0] D,
    input  logic       BYTE_LOAD,
    input  logic       DISPEN,
    input  logic       HSYNC,
    input  logic [1:0] MODE_REG,
    output logic [3:0] CIDX,
    output logic       INK_SEL,
    output logic       BORDER_SEL,
    output logic       COLOUR_KEEP,
    output logic       MODE_IS_0,
    output logic       MODE_IS_2
);

    logic [7:0] sr;
    logic [2:0] phase;
    logic [2:0] phase_next;
    logic       disp;
    logic       start;
    logic       shift;
    mode_t      mode;

    video_mode_sync u_mode_sync (
        .clk_n     (CLK_n),
        .reset_n   (RESET_n),
        .hsync     (HSYNC),
        .mode_reg  (MODE_REG),
        .byte_load (BYTE_LOAD),
        .mode      (mode),
        .mode_is_0 (MODE_IS_0),
        .mode_is_2 (MODE_IS_2)
    );

    always_comb begin
        phase_next = phase + 3'd1;
        shift      = ((phase_next[1:0] & shift_mask(mode)) == 2'b00);
    end

    // Without a load the phase keeps wrapping, so zeros shift out as index 0.
    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            sr    <= 8'h00;
            phase <= 3'd0;
            disp  <= 1'b0;
            start <= 1'b0;
        end else if (BYTE_LOAD) begin
            sr    <= D;
            phase <= 3'd0;
            disp  <= DISPEN;
            start <= 1'b1;
        end else begin
            phase <= phase_next;
            start <= shift;
            if (shift) begin
                sr <= {sr[6:0], 1'b0};
            end
        end
    end

    assign CIDX        = cidx_of(sr);
    assign INK_SEL     = start & disp;
    assign BORDER_SEL  = start & ~disp;
    assign COLOUR_KEEP = ~start;

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed bench for video_pixel_shifter: expected pixel outputs are queued per
// driven cycle and popped against the DUT outputs half a clock after each edge.
module tb_video_pixel_shifter;

    logic       CLK_n;
    logic       RESET_n;
    logic [7:0] D;
    logic       BYTE_LOAD;
    logic       DISPEN;
    logic       HSYNC;
    logic [1:0] MODE_REG;
    logic [3:0] CIDX;
    logic       INK_SEL;
    logic       BORDER_SEL;
    logic       COLOUR_KEEP;
    logic       MODE_IS_0;
    logic       MODE_IS_2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] sb[$];

    // {CIDX, INK_SEL, BORDER_SEL, COLOUR_KEEP, MODE_IS_0, MODE_IS_2}
    localparam logic [8:0] RST_VEC = {4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    video_pixel_shifter dut (
        .CLK_n       (CLK_n),
        .RESET_n     (RESET_n),
        .D           (D),
        .BYTE_LOAD   (BYTE_LOAD),
        .DISPEN      (DISPEN),
        .HSYNC       (HSYNC),
        .MODE_REG    (MODE_REG),
        .CIDX        (CIDX),
        .INK_SEL     (INK_SEL),
        .BORDER_SEL  (BORDER_SEL),
        .COLOUR_KEEP (COLOUR_KEEP),
        .MODE_IS_0   (MODE_IS_0),
        .MODE_IS_2   (MODE_IS_2)
    );

    initial begin
        CLK_n = 1'b0;
        forever #5 CLK_n = ~CLK_n;
    end

    function automatic logic [3:0] exp_cidx(input logic [7:0] v);
        return {v[1], v[5], v[3], v[7]};
    endfunction

    task automatic step(input logic bl, input logic [7:0] d, input logic [8:0] exp, input string tag);
        logic [8:0] obs;
        logic [8:0] e;
        BYTE_LOAD = bl;
        D         = d;
        sb.push_back(exp);
        @(posedge CLK_n);
        @(negedge CLK_n);
        obs = {CIDX, INK_SEL, BORDER_SEL, COLOUR_KEEP, MODE_IS_0, MODE_IS_2};
        e   = sb.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b (cidx,ink,border,keep,m0,m2)", tag, obs, e);
        end
    endtask

    // Runs ncyc cycles of one byte slot; pixel k starts every 'hold' cycles and
    // shows byte d shifted left by kbase+k. Non-load cycles drive a junk D.
    task automatic run_byte(input logic [7:0] d, input bit load, input int kbase, input int ncyc,
                            input bit disp, input int hold, input bit m0, input bit m2,
                            input int hs_cyc, input int dis_cyc, input string tag);
        logic [7:0] v;
        bit         st;
        bit         bl;
        int         k;
        for (int c = 0; c < ncyc; c++) begin
            HSYNC = (c == hs_cyc);
            if (c == dis_cyc) DISPEN = 1'b1;
            st = ((c % hold) == 0);
            k  = kbase + c / hold;
            v  = d << k;
            bl = load && (c == 0);
            step(bl, bl ? d : ~d, {exp_cidx(v), st & disp, st & ~disp, ~st, m0, m2},
                 $sformatf("%s_c%0d", tag, c));
        end
        HSYNC = 1'b0;
    endtask

    initial begin
        RESET_n   = 1'b0;
        D         = 8'h00;
        BYTE_LOAD = 1'b0;
        DISPEN    = 1'b0;
        HSYNC     = 1'b0;
        MODE_REG  = 2'd0;

        // Reset dominates a simultaneous load.
        step(1'b1, 8'hFF, RST_VEC, "reset0");
        step(1'b1, 8'hFF, RST_VEC, "reset1");
        RESET_n = 1'b1;
        DISPEN  = 1'b1;

        // HSYNC rise on the load cycle commits mode 2 for that very byte.
        MODE_REG = 2'd2;
        run_byte(8'hA5, 1, 0, 8, 1, 1, 0, 1, 0, -1, "m2_a5");

        // HSYNC rise mid-byte only arms the next byte (mode 1).
        MODE_REG = 2'd1;
        run_byte(8'h3C, 1, 0, 8, 1, 1, 0, 1, 5, -1, "m2_hs_mid");

        MODE_REG = 2'd0;
        run_byte(8'h88, 1, 0, 8, 1, 2, 0, 0, 6, -1, "m1_88");

        run_byte(8'hAA, 1, 0, 8, 1, 4, 1, 0, -1, -1, "m0_aa");

        // Border byte; DISPEN rising mid-byte is ignored until the next load.
        DISPEN = 1'b0;
        run_byte(8'hF0, 1, 0, 8, 0, 4, 1, 0, -1, 3, "m0_border");

        // MODE_REG write without HSYNC: nothing changes.
        MODE_REG = 2'd2;
        run_byte(8'h55, 1, 0, 8, 1, 4, 1, 0, -1, -1, "mreg_nohs");

        run_byte(8'hC3, 1, 0, 8, 1, 4, 1, 0, 2, -1, "hs_mid_m0");

        MODE_REG = 2'd3;
        run_byte(8'hA5, 1, 0, 8, 1, 1, 0, 1, 4, -1, "m2_after");

        // Mode 3: mode-0 timing with both flags low.
        run_byte(8'hAA, 1, 0, 8, 1, 4, 0, 0, -1, -1, "m3_aa");

        // Missing loads: phase wraps and the old byte keeps shifting out.
        run_byte(8'hAA, 0, 2, 8, 1, 4, 0, 0, -1, -1, "miss1");
        run_byte(8'hAA, 0, 4, 8, 1, 4, 0, 0, -1, -1, "miss2");

        // Early load discards the rest of the old byte.
        run_byte(8'hF0, 1, 0, 3, 1, 4, 0, 0, -1, -1, "early_old");
        MODE_REG = 2'd2;
        run_byte(8'h0F, 1, 0, 8, 1, 4, 0, 0, 2, -1, "early_new");

        // Reset at phase 3 of a mode-2 byte, with a load asserted alongside.
        run_byte(8'hA5, 1, 0, 4, 1, 1, 0, 1, -1, -1, "pre_rst");
        RESET_n = 1'b0;
        step(1'b1, 8'hFF, RST_VEC, "rst_mid");
        RESET_n = 1'b1;
        step(1'b0, 8'h00, RST_VEC, "rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
